// File: rtl/truth_table_sequencer_pkg.sv
// Shared types and sizes for the exhaustive truth-table sequencer and its settle timer.
package truth_table_sequencer_pkg;

    localparam int NUM_COMBOS = 8;
    localparam int IDX_W      = 3;
    localparam int CNT_W      = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETTLE = 3'd1,
        ST_SAMPLE = 3'd2,
        ST_CHECK  = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

endpackage

// File: rtl/truth_table_sequencer_settle_timer.sv
// Settle-time counter: clear restarts at zero, enable counts up, tc_o flags SETTLE_CYCLES-1.
module settle_timer
    import truth_table_sequencer_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic en_i,
    output logic tc_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tc_o = (cnt_q == CNT_W'(SETTLE_CYCLES - 1));

    // Counting stops at terminal count, so the counter cannot overflow its 4 bits.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (en_i && !tc_o) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/truth_table_sequencer.sv
// Drives all 8 {a,b,c} combinations into a combinational block, samples x/y after a settle
// time, and compares the measured truth tables against the expected ones.
module truth_table_sequencer
    import truth_table_sequencer_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter logic [7:0]  EXP_X         = 8'h00,
    parameter logic [7:0]  EXP_Y         = 8'h00
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       a,
    output logic       b,
    output logic       c,
    input  logic       x_in,
    input  logic       y_in,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] fail_idx,
    output logic [7:0] x_table,
    output logic [7:0] y_table
);

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [NUM_COMBOS-1:0]   x_tab_q, x_tab_d;
    logic [NUM_COMBOS-1:0]   y_tab_q, y_tab_d;
    logic                    pass_q, pass_d;
    logic [IDX_W-1:0]        fail_idx_q, fail_idx_d;

    logic                    tmr_clear;
    logic                    tmr_en;
    logic                    tmr_tc;
    logic [NUM_COMBOS-1:0]   mismatch;
    logic [IDX_W-1:0]        first_bad;

    settle_timer #(
        .SETTLE_CYCLES(SETTLE_CYCLES)
    ) u_settle_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear_i(tmr_clear),
        .en_i   (tmr_en),
        .tc_o   (tmr_tc)
    );

    // Lowest mismatching index wins; stays 0 when the tables agree.
    always_comb begin
        mismatch  = (x_tab_q ^ EXP_X) | (y_tab_q ^ EXP_Y);
        first_bad = '0;
        for (int i = NUM_COMBOS - 1; i >= 0; i--) begin
            if (mismatch[i]) begin
                first_bad = IDX_W'(i);
            end
        end
    end

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        x_tab_d    = x_tab_q;
        y_tab_d    = y_tab_q;
        pass_d     = pass_q;
        fail_idx_d = fail_idx_q;
        tmr_clear  = 1'b0;
        tmr_en     = 1'b0;

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d    = ST_SETTLE;
                    idx_d      = '0;
                    x_tab_d    = '0;
                    y_tab_d    = '0;
                    pass_d     = 1'b0;
                    fail_idx_d = '0;
                    tmr_clear  = 1'b1;
                end
            end
            ST_SETTLE: begin
                if (tmr_tc) begin
                    state_d = ST_SAMPLE;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            ST_SAMPLE: begin
                x_tab_d[idx_q] = x_in;
                y_tab_d[idx_q] = y_in;
                if (idx_q == IDX_W'(NUM_COMBOS - 1)) begin
                    state_d = ST_CHECK;
                end else begin
                    idx_d     = idx_q + IDX_W'(1);
                    tmr_clear = 1'b1;
                    state_d   = ST_SETTLE;
                end
            end
            ST_CHECK: begin
                pass_d     = (x_tab_q == EXP_X) && (y_tab_q == EXP_Y);
                fail_idx_d = first_bad;
                state_d    = ST_DONE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            x_tab_q    <= '0;
            y_tab_q    <= '0;
            pass_q     <= 1'b0;
            fail_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            x_tab_q    <= x_tab_d;
            y_tab_q    <= y_tab_d;
            pass_q     <= pass_d;
            fail_idx_q <= fail_idx_d;
        end
    end

    assign {a, b, c} = idx_q;
    assign busy      = (state_q == ST_SETTLE) || (state_q == ST_SAMPLE) || (state_q == ST_CHECK);
    assign done      = (state_q == ST_DONE);
    assign pass      = pass_q;
    assign fail_idx  = fail_idx_q;
    assign x_table   = x_tab_q;
    assign y_table   = y_tab_q;

endmodule

// File: tb/tb_truth_table_sequencer.sv
// Bench: parity/majority block model with injectable faults, table-driven sweeps plus
// hand-written restart, reset-abort and short-settle sequences.
module tb_truth_table_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start_r = 1'b0;
    logic       sel2 = 1'b0;
    logic [7:0] fx = 8'h00;
    logic [7:0] fy = 8'h00;

    logic       start1, a1, b1, c1, x1_in, y1_in, busy1, done1, pass1;
    logic [2:0] fail_idx1;
    logic [7:0] x_table1, y_table1;
    logic       start2, a2, b2, c2, x2_in, y2_in, busy2, done2, pass2;
    logic [2:0] fail_idx2;
    logic [7:0] x_table2, y_table2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign start1 = start_r & ~sel2;
    assign start2 = start_r & sel2;

    // Block under test: x = parity, y = majority, each with a per-index flip mask.
    assign x1_in = (a1 ^ b1 ^ c1) ^ fx[{a1, b1, c1}];
    assign y1_in = ((a1 & b1) | (a1 & c1) | (b1 & c1)) ^ fy[{a1, b1, c1}];
    assign x2_in = (a2 ^ b2 ^ c2) ^ fx[{a2, b2, c2}];
    assign y2_in = ((a2 & b2) | (a2 & c2) | (b2 & c2)) ^ fy[{a2, b2, c2}];

    truth_table_sequencer #(
        .SETTLE_CYCLES(2), .EXP_X(8'h96), .EXP_Y(8'hE8)
    ) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1),
        .a(a1), .b(b1), .c(c1), .x_in(x1_in), .y_in(y1_in),
        .busy(busy1), .done(done1), .pass(pass1), .fail_idx(fail_idx1),
        .x_table(x_table1), .y_table(y_table1)
    );

    truth_table_sequencer #(
        .SETTLE_CYCLES(1), .EXP_X(8'h96), .EXP_Y(8'hE8)
    ) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2),
        .a(a2), .b(b2), .c(c2), .x_in(x2_in), .y_in(y2_in),
        .busy(busy2), .done(done2), .pass(pass2), .fail_idx(fail_idx2),
        .x_table(x_table2), .y_table(y_table2)
    );

    wire [2:0] m_abc   = sel2 ? {a2, b2, c2} : {a1, b1, c1};
    wire       m_busy  = sel2 ? busy2 : busy1;
    wire       m_done  = sel2 ? done2 : done1;
    wire       m_pass  = sel2 ? pass2 : pass1;
    wire [2:0] m_fidx  = sel2 ? fail_idx2 : fail_idx1;
    wire [7:0] m_xtab  = sel2 ? x_table2 : x_table1;
    wire [7:0] m_ytab  = sel2 ? y_table2 : y_table1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Starts a sweep on the selected DUT and follows it to done. lat counts the start edge
    // as cycle 1, so done first seen after edge N means latency N. poke_k re-asserts start
    // during cycle poke_k of the sweep (0 = never).
    task automatic sweep(input int hold, input int poke_k, output int lat,
                         output int stim_bad, output logic entry_ok);
        start_r = 1'b1;
        @(posedge clk); #1;
        start_r = 1'b0;
        lat      = 1;
        stim_bad = 0;
        entry_ok = (m_done == 1'b0) && (m_busy == 1'b1) && (m_pass == 1'b0) &&
                   (m_xtab == 8'h00) && (m_ytab == 8'h00) && (m_fidx == 3'd0);
        while (m_done !== 1'b1 && lat < 200) begin
            if (lat <= 8 * hold) begin
                if (m_abc != 3'((lat - 1) / hold)) stim_bad++;
            end
            if (lat <= 8 * hold + 1 && m_busy !== 1'b1) stim_bad++;
            start_r = (lat == poke_k);
            @(posedge clk); #1;
            lat++;
        end
        start_r = 1'b0;
    endtask

    typedef struct {
        logic [7:0] fx;
        logic [7:0] fy;
        logic [7:0] ex;
        logic [7:0] ey;
        logic       ep;
        logic [2:0] ef;
        int         poke;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int   lat;
        int   sbad;
        logic eok;

        vecs[0] = '{8'h00, 8'h00, 8'h96, 8'hE8, 1'b1, 3'd0, 0};
        vecs[1] = '{8'h20, 8'h00, 8'hB6, 8'hE8, 1'b0, 3'd5, 0};
        vecs[2] = '{8'h04, 8'h44, 8'h92, 8'hAC, 1'b0, 3'd2, 0};
        vecs[3] = '{8'h00, 8'h00, 8'h96, 8'hE8, 1'b1, 3'd0, 10};
        vecs[4] = '{8'h80, 8'h08, 8'h16, 8'hE0, 1'b0, 3'd3, 0};
        vecs[5] = '{8'h01, 8'h00, 8'h97, 8'hE8, 1'b0, 3'd0, 0};
        vecs[6] = '{8'h00, 8'h80, 8'h96, 8'h68, 1'b0, 3'd7, 0};

        #2 rst_n = 1'b0;
        #1;
        check("rst_abc", 32'({a1, b1, c1}), 32'd0);
        check("rst_busy", 32'(busy1), 32'd0);
        check("rst_done", 32'(done1), 32'd0);
        check("rst_pass", 32'(pass1), 32'd0);
        check("rst_fidx", 32'(fail_idx1), 32'd0);
        check("rst_xtab", 32'(x_table1), 32'd0);
        check("rst_ytab", 32'(y_table1), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("idle_no_start", 32'({busy1, done1}), 32'd0);

        for (int v = 0; v < 7; v++) begin
            fx = vecs[v].fx;
            fy = vecs[v].fy;
            sweep(3, vecs[v].poke, lat, sbad, eok);
            check($sformatf("v%0d_latency", v), 32'(lat), 32'd26);
            check($sformatf("v%0d_stim", v), 32'(sbad), 32'd0);
            check($sformatf("v%0d_entry", v), 32'(eok), 32'd1);
            check($sformatf("v%0d_xtab", v), 32'(x_table1), 32'(vecs[v].ex));
            check($sformatf("v%0d_ytab", v), 32'(y_table1), 32'(vecs[v].ey));
            check($sformatf("v%0d_pass", v), 32'(pass1), 32'(vecs[v].ep));
            check($sformatf("v%0d_fidx", v), 32'(fail_idx1), 32'(vecs[v].ef));
            check($sformatf("v%0d_busy_done", v), 32'(busy1), 32'd0);
            repeat (2) @(posedge clk);
            #1;
            check($sformatf("v%0d_held", v), 32'({done1, pass1, fail_idx1}),
                  32'({1'b1, vecs[v].ep, vecs[v].ef}));
        end

        // Reset in the middle of a sweep while idx=4.
        fx = 8'h00;
        fy = 8'h00;
        start_r = 1'b1;
        @(posedge clk); #1;
        start_r = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        check("pre_abort_abc", 32'({a1, b1, c1}), 32'd4);
        check("pre_abort_xtab", 32'(x_table1), 32'h06);
        rst_n = 1'b0;
        #1;
        check("abort_abc", 32'({a1, b1, c1}), 32'd0);
        check("abort_busy", 32'(busy1), 32'd0);
        check("abort_xtab", 32'(x_table1), 32'd0);
        check("abort_ytab", 32'(y_table1), 32'd0);
        check("abort_done", 32'(done1), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("post_abort_idle", 32'({busy1, done1, a1, b1, c1}), 32'd0);
        sweep(3, 0, lat, sbad, eok);
        check("after_abort_latency", 32'(lat), 32'd26);
        check("after_abort_stim", 32'(sbad), 32'd0);
        check("after_abort_pass", 32'(pass1), 32'd1);
        check("after_abort_tabs", 32'({x_table1, y_table1}), 32'h96E8);

        // Short settle: two back-to-back sweeps, the second started from DONE.
        sel2 = 1'b1;
        fx = 8'h20;
        sweep(2, 0, lat, sbad, eok);
        check("s1_first_latency", 32'(lat), 32'd18);
        check("s1_first_stim", 32'(sbad), 32'd0);
        check("s1_first_xtab", 32'(x_table2), 32'hB6);
        check("s1_first_result", 32'({pass2, fail_idx2}), 32'({1'b0, 3'd5}));
        fx = 8'h00;
        sweep(2, 0, lat, sbad, eok);
        check("s1_second_entry_clear", 32'(eok), 32'd1);
        check("s1_second_latency", 32'(lat), 32'd18);
        check("s1_second_stim", 32'(sbad), 32'd0);
        check("s1_second_tabs", 32'({x_table2, y_table2}), 32'h96E8);
        check("s1_second_result", 32'({pass2, fail_idx2}), 32'({1'b1, 3'd0}));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/truth_table_sequencer.md
Name: truth_table_sequencer

Overview:
- Exhaustive stimulus/capture controller for a 3-input, 2-output combinational block (inputs a, b, c; outputs x, y) under test.
- On start, steps the block through all 8 input combinations in binary order, waits a settle time, and samples x and y each step.
- Builds the measured truth tables and compares them against expected tables.
- Sits beside the combinational block on the board, replacing the hand-written stimulus sequence with hardware self-test.

Parameters:
SETTLE_CYCLES, 2, clock cycles between driving a new combination and sampling x/y; legal range 1..15.
EXP_X, 8'h00, expected x truth table; bit i = expected x for input index i = {a,b,c}.
EXP_Y, 8'h00, expected y truth table; same indexing.

Ports:
clk  input  1  system clock.
rst_n  input  1  asynchronous reset, active low; all state is cleared immediately on assertion.
start  input  1  single-cycle request; ignored unless the FSM is in IDLE or DONE.
a  output  1  stimulus MSB (index bit 2).
b  output  1  stimulus index bit 1.
c  output  1  stimulus LSB (index bit 0).
x_in  input  1  x output of the block under test.
y_in  input  1  y output of the block under test.
busy  output  1  high while a sweep is in progress.
done  output  1  high from sweep completion until the next accepted start.
pass  output  1  valid while done=1; 1 when both tables match.
fail_idx  output  3  lowest index where x or y mismatched; 0 when pass=1.
x_table  output  8  measured x table.
y_table  output  8  measured y table.

Behaviour:
- Reset values: a=b=c=0, busy=0, done=0, pass=0, fail_idx=0, x_table=0, y_table=0. FSM in IDLE, index counter idx=0, settle counter=0.
- {a,b,c} is driven combinationally from the registered idx at all times, so stimulus changes one cycle after idx updates.
- State machine:
  - IDLE: on start, go to SETTLE with idx=0, settle counter cleared, and x_table/y_table cleared. busy rises on the following cycle.
  - SETTLE: increment the settle counter each cycle. When it reaches SETTLE_CYCLES-1, go to SAMPLE.
  - SAMPLE (one cycle): write x_table[idx]<=x_in and y_table[idx]<=y_in.
    - If idx==7, go to CHECK.
    - Otherwise increment idx, clear the settle counter, and go to SETTLE.
  - CHECK (one cycle):
    - pass <= (x_table==EXP_X) && (y_table==EXP_Y).
    - fail_idx <= lowest set bit of ((x_table^EXP_X)|(y_table^EXP_Y)), or 0 if none.
    - Then go to DONE.
  - DONE: done=1, busy=0. Tables, pass and fail_idx are held. A start here behaves as in IDLE: it clears done, pass, fail_idx and the tables.
- busy=1 in SETTLE, SAMPLE and CHECK only.
- Latency from the start cycle to done=1 is 8*(SETTLE_CYCLES+1)+2 cycles. With SETTLE_CYCLES=2 this is 26.
- Each combination is held for exactly SETTLE_CYCLES+1 cycles. The sample is taken at the end of the final hold cycle.
- idx is 3 bits. It never wraps during a sweep; the transition 7→0 happens only on a new start.
- start while busy=1 is ignored entirely: no restart and no queuing.
- rst_n asserted mid-sweep aborts immediately: all outputs return to their reset values, including the stimulus going to 000.
- When rst_n is released, the FSM sits in IDLE until a start arrives. No partial results are retained.
- start and rst_n low in the same cycle: reset wins.

Decomposition:
- Shared package/header: state encodings (IDLE, SETTLE, SAMPLE, CHECK, DONE as 3-bit localparams), NUM_COMBOS=8, IDX_W=3.
- One natural sub-module: settle_timer (load/clear, count up to SETTLE_CYCLES-1, terminal-count flag). It is reusable by other stimulus sequencers in the practice set.
- Priority encoder for fail_idx stays inline.

Test Plan:
- Model the block under test as x=a^b^c, y=majority(a,b,c), with EXP_X=8'h96, EXP_Y=8'hE8 and SETTLE_CYCLES=2. Pulse start → {a,b,c} steps 000..111, each held 3 cycles. done rises 26 cycles after start with x_table=8'h96, y_table=8'hE8, pass=1, fail_idx=0.
- Same setup, but the model forces x=1 at index 5 → x_table=8'hB6, pass=0, fail_idx=5.
- Bad model with both x and y wrong at index 2 and y wrong at index 6 → pass=0, fail_idx=2.
- Pulse start again during the sweep, at idx=3 → ignored: the sweep continues and done still arrives at cycle 26 from the original start.
- Drop rst_n for 1 cycle while idx=4 → a=b=c=0, busy=0, tables=0 immediately. A new start then gives a full correct sweep with pass=1.
- Set SETTLE_CYCLES=1 and pulse start twice back-to-back from DONE → each combination is held 2 cycles, done arrives after 18 cycles, and the second start clears done/pass and the tables on entry.
